fifo_wr_arb_ctrl: RTL and testbench

- Single-clock controller that sequences an 8-entry-default FIFO storage array: owns write/read pointers, full/empty/count flags, and the storage write enable.
- Shares the single storage write port between two requesters using round-robin arbitration with a valid/ready handshake.
- Sits between two producers and the storage array; the consumer pops through a valid/pop interface and reads storage data combinationally at the read pointer.

---
 rtl/fifo_wr_arb_ctrl_if.sv | 39 +++
 rtl/fifo_wr_arb_ctrl.sv | 98 +++++++++
 tb/tb_fifo_wr_arb_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arb_ctrl_if.sv
// Handshake and status bundle between two producers, one consumer and the
// fifo_wr_arb_ctrl write-arbitrating FIFO controller.
interface fifo_wr_arb_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PTR_WIDTH  = 3
);
  logic                  req0_valid;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_ready;
  logic                  req1_valid;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_ready;
  logic                  pop;
  logic                  rd_valid;
  logic                  w_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic [PTR_WIDTH:0]    bin_wptr;
  logic [PTR_WIDTH:0]    bin_rptr;
  logic                  full;
  logic                  empty;
  logic [PTR_WIDTH:0]    count;
  logic                  almost_full;
  logic                  last_grant;
  logic                  underflow_err;

  // Controller side
  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, pop,
    output req0_ready, req1_ready, rd_valid, w_en, data_in, bin_wptr, bin_rptr,
           full, empty, count, almost_full, last_grant, underflow_err
  );

  // Producer/consumer side
  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, pop,
    input  req0_ready, req1_ready, rd_valid, w_en, data_in, bin_wptr, bin_rptr,
           full, empty, count, almost_full, last_grant, underflow_err
  );
endinterface

// File: rtl/fifo_wr_arb_ctrl.sv
// FIFO pointer/flag controller whose single storage write port is shared by two
// requesters under round-robin arbitration; storage itself lives outside.
module fifo_wr_arb_ctrl #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PTR_WIDTH  = 3,
  parameter int unsigned AF_LEVEL   = 6
) (
  input logic              clock,
  input logic              reset,
  fifo_wr_arb_ctrl_if.slave bus
);

  // A level above DEPTH could never be reached; clamp so the flag still means "full".
  localparam logic [PTR_WIDTH:0] AfLevel =
      (AF_LEVEL > DEPTH) ? DEPTH[PTR_WIDTH:0] : AF_LEVEL[PTR_WIDTH:0];

  logic [PTR_WIDTH:0] wptr_q, wptr_d;
  logic [PTR_WIDTH:0] rptr_q, rptr_d;
  logic [PTR_WIDTH:0] count_q, count_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic               af_q, af_d;
  logic               last_grant_q, last_grant_d;
  logic               underflow_q, underflow_d;

  logic grant0, grant1;
  logic push, do_pop;

  // Arbitration looks only at registered state, so ready never depends on pop.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!full_q) begin
      unique case ({bus.req1_valid, bus.req0_valid})
        2'b01: grant0 = 1'b1;
        2'b10: grant1 = 1'b1;
        2'b11: begin
          if (last_grant_q) grant0 = 1'b1;
          else              grant1 = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign push   = (bus.req0_valid & grant0) | (bus.req1_valid & grant1);
  assign do_pop = bus.pop & ~empty_q;

  always_comb begin
    wptr_d       = wptr_q + (PTR_WIDTH + 1)'(push);
    rptr_d       = rptr_q + (PTR_WIDTH + 1)'(do_pop);
    count_d      = wptr_d - rptr_d;
    empty_d      = (wptr_d == rptr_d);
    full_d       = (wptr_d[PTR_WIDTH] != rptr_d[PTR_WIDTH]) &&
                   (wptr_d[PTR_WIDTH-1:0] == rptr_d[PTR_WIDTH-1:0]);
    af_d         = (count_d >= AfLevel);
    last_grant_d = push ? grant1 : last_grant_q;
    underflow_d  = underflow_q | (bus.pop & empty_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      af_q         <= 1'b0;
      last_grant_q <= 1'b1;
      underflow_q  <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      af_q         <= af_d;
      last_grant_q <= last_grant_d;
      underflow_q  <= underflow_d;
    end
  end

  assign bus.req0_ready    = grant0;
  assign bus.req1_ready    = grant1;
  assign bus.w_en          = push;
  assign bus.data_in       = grant1 ? bus.req1_data : bus.req0_data;
  assign bus.rd_valid      = ~empty_q;
  assign bus.bin_wptr      = wptr_q;
  assign bus.bin_rptr      = rptr_q;
  assign bus.count         = count_q;
  assign bus.full          = full_q;
  assign bus.empty         = empty_q;
  assign bus.almost_full   = af_q;
  assign bus.last_grant    = last_grant_q;
  assign bus.underflow_err = underflow_q;

endmodule

// File: tb/tb_fifo_wr_arb_ctrl.sv
// Scoreboard bench: stimulus predicts each cycle from a queue-based FIFO model,
// a monitor compares the DUT (with a bench-side storage array) off the clock edge.
module tb_fifo_wr_arb_ctrl;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned DW    = 8;
  localparam int unsigned PW    = 3;
  localparam int unsigned AF    = 6;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  fifo_wr_arb_ctrl_if #(.DATA_WIDTH(DW), .PTR_WIDTH(PW)) bus ();

  fifo_wr_arb_ctrl #(
    .DEPTH(DEPTH), .DATA_WIDTH(DW), .PTR_WIDTH(PW), .AF_LEVEL(AF)
  ) u_dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // Storage array the controller sequences.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clock) if (bus.w_en === 1'b1) mem[bus.bin_wptr[PW-1:0]] <= bus.data_in;
  logic [DW-1:0] rd_data;
  assign rd_data = mem[bus.bin_rptr[PW-1:0]];

  typedef struct {
    bit          en;
    bit          r0, r1, wen, rdv, full, empty, af, lg, uf, dchk;
    logic [DW-1:0] din, data;
    logic [PW:0]   cnt, wp, rp;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DW-1:0] mq[$];
  logic [PW:0]   n_push = '0;
  logic [PW:0]   n_pop  = '0;
  bit            lg = 1'b1;
  bit            uf = 1'b0;
  bit            known = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h want=%0h", name, $time, act, exp);
    end
  endtask

  task automatic step(input bit v0, input logic [DW-1:0] d0, input bit v1,
                      input logic [DW-1:0] d1, input bit p, input bit rst);
    exp_t e;
    int   g;
    int   sz;
    @(negedge clock);
    reset          = rst;
    bus.req0_valid = v0;
    bus.req0_data  = d0;
    bus.req1_valid = v1;
    bus.req1_data  = d1;
    bus.pop        = p;
    sz = mq.size();
    g  = -1;
    if (sz < DEPTH) begin
      if (v0 && v1) g = lg ? 0 : 1;
      else if (v0)  g = 0;
      else if (v1)  g = 1;
    end
    e.en    = known && !rst;
    e.r0    = (g == 0);
    e.r1    = (g == 1);
    e.wen   = (g >= 0);
    e.din   = (g == 1) ? d1 : d0;
    e.rdv   = (sz != 0);
    e.full  = (sz == DEPTH);
    e.empty = (sz == 0);
    e.af    = (sz >= AF);
    e.cnt   = sz[PW:0];
    e.wp    = n_push;
    e.rp    = n_pop;
    e.lg    = lg;
    e.uf    = uf;
    e.dchk  = p && (sz != 0);
    e.data  = (sz != 0) ? mq[0] : '0;
    exp_q.push_back(e);
    if (rst) begin
      mq.delete();
      n_push = '0;
      n_pop  = '0;
      lg     = 1'b1;
      uf     = 1'b0;
      known  = 1'b1;
    end else begin
      if (p && sz != 0) begin
        void'(mq.pop_front());
        n_pop++;
      end else if (p) begin
        uf = 1'b1;
      end
      if (g >= 0) begin
        mq.push_back((g == 1) ? d1 : d0);
        n_push++;
        lg = (g == 1);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 8'h00, 0, 0);
  endtask

  // Monitor: samples mid-low-phase, well away from the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #3;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (e.en) begin
          chk("req0_ready", bus.req0_ready, e.r0);
          chk("req1_ready", bus.req1_ready, e.r1);
          chk("w_en", bus.w_en, e.wen);
          chk("data_in", bus.data_in, e.din);
          chk("rd_valid", bus.rd_valid, e.rdv);
          chk("full", bus.full, e.full);
          chk("empty", bus.empty, e.empty);
          chk("almost_full", bus.almost_full, e.af);
          chk("count", bus.count, e.cnt);
          chk("bin_wptr", bus.bin_wptr, e.wp);
          chk("bin_rptr", bus.bin_rptr, e.rp);
          chk("last_grant", bus.last_grant, e.lg);
          chk("underflow_err", bus.underflow_err, e.uf);
          if (e.dchk) chk("rd_data", rd_data, e.data);
        end
      end
    end
  end

  initial begin
    int guard;
    bus.req0_valid = 1'b0;
    bus.req0_data  = '0;
    bus.req1_valid = 1'b0;
    bus.req1_data  = '0;
    bus.pop        = 1'b0;

    step(0, 0, 0, 0, 0, 1);
    idle(3);
    // Single requester, then drain
    step(1, 8'h11, 0, 0, 0, 0);
    step(1, 8'h22, 0, 0, 0, 0);
    step(1, 8'h33, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0);
    // Both valid: alternation
    for (int i = 0; i < 4; i++) step(1, 8'hA0 + DW'(i), 1, 8'hB0 + DW'(i), 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0);
    // Fill to full, hold valids, pop one, push one (wrap)
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 11; i++) step(1, 8'h40 + DW'(i), 1, 8'h60 + DW'(i), 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(1, 8'h5A, 0, 0, 0, 0);
    idle(1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0);
    // Count 4, push and pop together
    step(1, 8'hC1, 0, 0, 1, 0);
    step(0, 0, 1, 8'hC2, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 0);
    // Underflow, then reset mid-stream at count 5
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 8'hD0 + DW'(i), 0, 0, 0, 0);
    step(1, 8'hEE, 1, 8'hEF, 1, 1);
    idle(2);
    // Randomized phases: fill-biased, drain-biased, balanced
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 600; i++) begin
        int pp;
        pp = (ph == 0) ? 25 : (ph == 1) ? 75 : 50;
        step(bit'($urandom_range(0, 1)), DW'($urandom), bit'($urandom_range(0, 1)),
             DW'($urandom), bit'($urandom_range(0, 99) < pp),
             bit'($urandom_range(0, 299) == 0));
      end
    end
    idle(2);

    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got=%0d pending want=0", exp_q.size());
    end
    #10;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
